// File: rtl/pc_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch front end.
package pc_fetch_pkg;

  localparam int unsigned INSN_W       = 16;
  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_fifo.sv
// Small synchronous FIFO holding {instruction, pc} pairs; head is read straight
// from registered storage so the consumer sees no path from its own stall input.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // Full-and-popping frees the slot in the same edge, so that push is legal.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset too, because the head feeds the outputs directly
      // and those must read as zero straight after reset.
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch front end: owns the PC, issues one-cycle-latency memory reads, buffers
// returned words and hands them to the parser with back pressure and redirect.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       DEPTH    = 2   // must be at least 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INSN_W-1:0] code,
  output logic [ADDR_W-1:0] code_pc,
  output logic              pc_fetch_done,
  input  logic              code_paser_back_pressure
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = INSN_W + ADDR_W;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_inflight;
  logic              r_dead;

  logic              w_req;
  logic              w_pop;
  logic              w_push;
  logic              w_live_resp;
  logic              w_room;
  logic [OCC_W-1:0]  w_occ;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [ENT_W-1:0]  w_fifo_head;

  assign pc_fetch_done = !w_fifo_empty;
  assign w_pop         = pc_fetch_done && !code_paser_back_pressure;
  assign w_live_resp   = r_inflight && !r_dead;
  assign w_push        = w_live_resp && !redirect_valid;

  // Occupancy once this cycle settles; pop implies count >= 1 so it cannot underflow.
  assign w_occ  = OCC_W'(w_fifo_count) + OCC_W'(w_live_resp) - OCC_W'(w_pop);
  assign w_room = (w_occ < OCC_W'(DEPTH));

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      BOOT:    w_state_nxt = FETCH;
      FETCH:   w_req       = w_room;
      FLUSH:   w_state_nxt = FETCH;
      default: w_state_nxt = BOOT;
    endcase
    if (redirect_valid) begin
      w_state_nxt = FLUSH;
      w_req       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_dead     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_req;
      r_dead     <= redirect_valid;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_req) begin
        r_pc       <= r_pc + 1'b1;
        r_req_addr <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({imem_rdata, r_req_addr}),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_head      (w_fifo_head)
  );

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign code      = w_fifo_head[ADDR_W +: INSN_W];
  assign code_pc   = w_fifo_head[ADDR_W-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: startup, back pressure, wrap, redirects, mid-stream reset.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bp  = 1'b0;
  logic        rv  = 1'b0;
  logic [15:0] rpc = '0;

  logic        req0, req1, done0, done1;
  logic [15:0] addr0, addr1, code0, code1, cpc0, cpc1;
  logic [15:0] rdata0 = '0;
  logic [15:0] rdata1 = '0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word stored at an address equals the address.
  always @(posedge clk) begin
    if (req0) rdata0 <= addr0;
    if (req1) rdata1 <= addr1;
  end

  pc_fetch #(.ADDR_W(16), .RESET_PC(16'h0000), .DEPTH(2)) u_dut0 (
    .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
    .redirect_valid(rv), .redirect_pc(rpc), .code(code0), .code_pc(cpc0),
    .pc_fetch_done(done0), .code_paser_back_pressure(bp));

  pc_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFE), .DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .redirect_valid(rv), .redirect_pc(rpc), .code(code1), .code_pc(cpc1),
    .pc_fetch_done(done1), .code_paser_back_pressure(bp));

  typedef struct {
    logic        bp;
    logic        req;
    logic [15:0] addr;
    logic        done;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic b, input logic r, input logic v, input logic [15:0] p);
    @(negedge clk);
    bp  = b;
    rst = r;
    rv  = v;
    rpc = p;
    #1;
  endtask

  task automatic expect_dut(input int which, input string tag, input logic e_req,
                            input logic [15:0] e_addr, input logic e_done,
                            input logic [15:0] e_pc);
    logic        a_req, a_done;
    logic [15:0] a_addr, a_pc, a_code;
    a_req  = (which == 0) ? req0  : req1;
    a_done = (which == 0) ? done0 : done1;
    a_addr = (which == 0) ? addr0 : addr1;
    a_pc   = (which == 0) ? cpc0  : cpc1;
    a_code = (which == 0) ? code0 : code1;
    check($sformatf("d%0d %s req", which, tag), 32'(a_req), 32'(e_req));
    if (e_req) check($sformatf("d%0d %s addr", which, tag), 32'(a_addr), 32'(e_addr));
    check($sformatf("d%0d %s done", which, tag), 32'(a_done), 32'(e_done));
    if (e_done) begin
      check($sformatf("d%0d %s code_pc", which, tag), 32'(a_pc), 32'(e_pc));
      check($sformatf("d%0d %s code", which, tag), 32'(a_code), 32'(e_pc));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req0"},  32'(req0),  32'h0);
    check({tag, " addr0"}, 32'(addr0), 32'h0000);
    check({tag, " code0"}, 32'(code0), 32'h0);
    check({tag, " cpc0"},  32'(cpc0),  32'h0);
    check({tag, " done0"}, 32'(done0), 32'h0);
    check({tag, " req1"},  32'(req1),  32'h0);
    check({tag, " addr1"}, 32'(addr1), 32'hFFFE);
    check({tag, " code1"}, 32'(code1), 32'h0);
    check({tag, " cpc1"},  32'(cpc1),  32'h0);
    check({tag, " done1"}, 32'(done1), 32'h0);
  endtask

  initial begin
    // Startup then back pressure c4..c8; addr/pc shown for RESET_PC=0.
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vecs[9]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h0001};
    vecs[10] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0002};
    vecs[11] = '{1'b0, 1'b1, 16'h0005, 1'b1, 16'h0003};
    vecs[12] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0004};

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("in_reset");

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].bp, 1'b0, 1'b0, 16'h0000);
      expect_dut(0, $sformatf("c%0d", i), vecs[i].req, vecs[i].addr,
                 vecs[i].done, vecs[i].pc);
      expect_dut(1, $sformatf("c%0d", i), vecs[i].req, vecs[i].addr + 16'hFFFE,
                 vecs[i].done, vecs[i].pc + 16'hFFFE);
    end

    // Redirect to 0x40 while addr 6 is in flight and head PC 5 transfers.
    drive(1'b0, 1'b0, 1'b1, 16'h0040); expect_dut(0, "rd_t",   1'b0, 16'h0000, 1'b1, 16'h0005);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rd_t+1", 1'b0, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rd_t+2", 1'b1, 16'h0040, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rd_t+3", 1'b1, 16'h0041, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rd_t+4", 1'b1, 16'h0042, 1'b1, 16'h0040);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rd_t+5", 1'b1, 16'h0043, 1'b1, 16'h0041);

    // Back-to-back redirects: the one landing in FLUSH wins.
    drive(1'b0, 1'b0, 1'b1, 16'h0080); expect_dut(0, "rr_t",   1'b0, 16'h0000, 1'b1, 16'h0042);
    drive(1'b0, 1'b0, 1'b1, 16'h0090); expect_dut(0, "rr_t+1", 1'b0, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rr_t+2", 1'b0, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rr_t+3", 1'b1, 16'h0090, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rr_t+4", 1'b1, 16'h0091, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rr_t+5", 1'b1, 16'h0092, 1'b1, 16'h0090);

    // Fill under back pressure, pulse reset, then restart cleanly from RESET_PC.
    drive(1'b1, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_bp0", 1'b0, 16'h0000, 1'b1, 16'h0091);
    drive(1'b1, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_bp1", 1'b0, 16'h0000, 1'b1, 16'h0091);
    drive(1'b1, 1'b1, 1'b0, 16'h0000); expect_dut(0, "rs_rst", 1'b0, 16'h0000, 1'b1, 16'h0091);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    check_reset_outputs("after_reset");
    drive(1'b1, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_c1", 1'b1, 16'h0000, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_c2", 1'b1, 16'h0001, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_c3", 1'b0, 16'h0000, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_c4", 1'b1, 16'h0002, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_c5", 1'b1, 16'h0003, 1'b1, 16'h0001);
    drive(1'b0, 1'b0, 1'b0, 16'h0000); expect_dut(0, "rs_c6", 1'b1, 16'h0004, 1'b1, 16'h0002);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction fetch front end that feeds the code parser. Holds the program counter and issues word reads to a synchronous instruction memory (one-cycle read latency). Buffers returned 16-bit instruction words in a small FIFO and presents them with a `pc_fetch_done` valid, honouring the parser's `code_paser_back_pressure`. Supports a single-cycle PC redirect from downstream for branches and jumps.

## Interface
Parameters:
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 0: first fetch address after reset.
- `DEPTH`, 2: instruction buffer entries; must be ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  read strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word address, valid when `imem_req`=1.
- `imem_rdata`  in  16  read data, valid the cycle after the `imem_req` cycle.
- `redirect_valid`  in  1  one-cycle pulse: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  ADDR_W  new PC, sampled when `redirect_valid`=1.
- `code`  out  16  instruction word at FIFO head.
- `code_pc`  out  ADDR_W  address `code` was fetched from.
- `pc_fetch_done`  out  1  `code`/`code_pc` valid.
- `code_paser_back_pressure`  in  1  parser not accepting; head must be held.

## Operation
- Transfer: a cycle with `pc_fetch_done`=1 and `code_paser_back_pressure`=0 pops the head. While back-pressured, `code`, `code_pc`, and `pc_fetch_done` stay stable.
- FSM states:
  - `BOOT`: the reset state; lasts exactly one cycle after `rst` falls; no request; moves to `FETCH`.
  - `FETCH`: normal issue.
  - `FLUSH`: entered on `redirect_valid`; lasts one cycle; moves to `FETCH`.
- Issue rule (in `FETCH`): `imem_req` = (`count` + `inflight` − `pop`) < `DEPTH`, where `inflight` is 1 if a response is due this cycle. `imem_addr` = `pc`.
- When `imem_req`=1: `pc` ← `pc`+1 and `inflight` ← 1 next cycle.
- PC arithmetic is modulo 2^ADDR_W; all-ones wraps to 0.
- Response: in the cycle after a live request, {`imem_rdata`, request address} is pushed to the FIFO.
- Redirect in cycle t:
  - `imem_req`=0 in t.
  - FIFO cleared at the end of t; a head transfer in t still counts as delivered.
  - The response due in t+1 is marked dead and not pushed.
  - `pc` ← `redirect_pc`; state ← `FLUSH`.
  - Redirect has priority over issue, push, and pop.
- Redirect during `FLUSH` or `BOOT` is accepted with the same rules; the latest redirect wins.
- Reset mid-operation: FIFO, `inflight`, and dead-flag cleared; a memory response arriving after reset is ignored.
- FIFO never overflows by construction; a push into a full FIFO is an assertion failure.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `code`=0, `code_pc`=0, `pc_fetch_done`=0, state=`BOOT`.
- First `rst`-low cycle = c0 (`BOOT`).
  - c1: `imem_req`=1, addr `RESET_PC`.
  - c2: data returns and is pushed.
  - c3: `pc_fetch_done`=1.
- Fetch-to-present latency: request cycle + 2.
- Steady state with no back pressure: one instruction per cycle, consecutive `code_pc` values.
- Redirect at t: `pc_fetch_done`=0 from t+1; request for `redirect_pc` at t+2 (after `FLUSH`); `pc_fetch_done`=1 at t+4.
- Back pressure held N cycles: at most `DEPTH` words buffered. Issue resumes so that the first post-release pop is followed by back-to-back words, with no bubble for `DEPTH` ≥ 2.
- Outputs `code`, `code_pc`, `pc_fetch_done` are driven from registered FIFO state, with no combinational path from `code_paser_back_pressure`.
- `imem_req` does depend combinationally on the pop condition.

## Structure
- Shared package/include:
  - Instruction width constant `INSN_W`=16.
  - Default `ADDR_W` and `RESET_PC`.
  - Fetch FSM state encodings `BOOT`/`FETCH`/`FLUSH`.
- Sub-module `fetch_fifo`: synchronous FIFO with parameters `DEPTH` and width `INSN_W`+`ADDR_W`.
  - Ports: push, pop, flush, full, empty, count.
  - Registered head output; a simultaneous push and pop on a full FIFO is legal.
- Top level holds the PC, the `inflight`/dead flags, the FSM, and the issue logic.

## Test plan
- Reset release, memory returning word = address, no back pressure → `pc_fetch_done` rises at c3 with `code_pc`=0, `code`=0x0000, then 1, 2, 3 on consecutive cycles.
- Back pressure high for 5 cycles from c4 → `code`/`code_pc` frozen at PC 1; `imem_req` low once 2 words are buffered; after release, PCs 1, 2, 3… are delivered with no gaps and none lost or duplicated.
- `redirect_valid` with `redirect_pc`=0x0040 at t while a request is in flight → stale word never appears; `pc_fetch_done` low t+1..t+3; `code_pc`=0x0040 at t+4.
- `RESET_PC`=0xFFFE → delivered PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `rst` pulsed for one cycle mid-stream with back pressure high → all outputs return to reset values; the post-reset stream restarts at `RESET_PC` with no stale word.
- Redirect on the same cycle as a head transfer → the transferred word is counted exactly once; the next word delivered is the redirect target.
